// File: rtl/min_reduce_int8_stream.sv
// min_reduce_int8_stream: stream min-reduction of signed frames into {min, index, count, trunc}
//
// gt_int_nbit  : signed a > b comparator (IMPL_TYPE selects the formulation)
// min_int8     : signed min select, returns A unless A > B
// min_reduce_int8_stream ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           input element handshake
//   in_data, in_last            signed element, end-of-frame marker
//   out_valid/out_ready         result handshake, result held until accepted
//   out_min, out_idx, out_count frame minimum, its 0-based position, element count
//   out_trunc                   frame closed by MAX_LEN without in_last

module gt_int_nbit #(
    parameter int WIDTH     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_gt
);
    generate
        if (IMPL_TYPE == 0) begin : g_signed
            assign o_gt = $signed(i_a) > $signed(i_b);
        end else begin : g_biased
            // Flipping the sign bits maps two's-complement order onto unsigned order.
            assign o_gt = {~i_a[WIDTH-1], i_a[WIDTH-2:0]} > {~i_b[WIDTH-1], i_b[WIDTH-2:0]};
        end
    endgenerate
endmodule

module min_int8 #(
    parameter int WIDTH     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_min
);
    logic w_gt;
    gt_int_nbit #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_gt (.i_a(i_a), .i_b(i_b), .o_gt(w_gt));
    assign o_min = w_gt ? i_b : i_a;
endmodule

module min_reduce_int8_stream #(
    parameter int   WIDTH     = 8,
    parameter int   MAX_LEN   = 16,
    parameter int   IMPL_TYPE = 0,
    localparam int  IDX_W     = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_count,
    output logic             out_trunc
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_min;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W:0]   r_cnt;
    logic             r_trunc;
    logic [WIDTH-1:0] w_min;
    logic [IDX_W:0]   w_cnt_inc;
    logic             w_acc;
    logic             w_xfer;
    logic             w_close_max;

    min_int8 #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_min (.i_a(r_min), .i_b(in_data), .o_min(w_min));

    assign in_ready    = r_state != S_DONE;
    assign out_valid   = r_state == S_DONE;
    assign w_acc       = in_valid & in_ready;
    assign w_xfer      = out_valid & out_ready;
    assign w_cnt_inc   = r_cnt + (IDX_W+1)'(1);
    assign w_close_max = w_cnt_inc == (IDX_W+1)'(MAX_LEN);
    assign out_min     = r_min;
    assign out_idx     = r_idx;
    assign out_count   = r_cnt;
    assign out_trunc   = r_trunc;

    always_ff @(posedge clk)
        r_state <= rst ? S_IDLE : w_next;

    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE && w_acc)
            w_next = in_last ? S_DONE : S_ACCUM;
        else if (r_state == S_ACCUM && w_acc && (in_last || w_close_max))
            w_next = S_DONE;
        else if (r_state == S_DONE && w_xfer)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_min   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_trunc <= 1'b0;
        end else if (w_acc) begin
            if (r_state == S_IDLE) begin
                r_min   <= in_data;
                r_idx   <= '0;
                r_cnt   <= (IDX_W+1)'(1);
                r_trunc <= 1'b0;
            end else begin
                r_min   <= w_min;
                // The min only changes on a strictly smaller element, so ties keep the earlier index.
                if (w_min != r_min)
                    r_idx <= r_cnt[IDX_W-1:0];
                r_cnt   <= w_cnt_inc;
                r_trunc <= ~in_last & w_close_max;
            end
        end
    end
endmodule

// File: tb/tb_min_reduce_int8_stream.sv
// tb_min_reduce_int8_stream: directed and randomized frames checked against a frame-level model
module tb_min_reduce_int8_stream;
    localparam int MAX = 16;

    typedef struct {
        logic [7:0] mn;
        logic [3:0] idx;
        logic [4:0] cnt;
        logic       tr;
    } res_t;

    logic       clk = 0;
    logic       rst = 1;
    logic       in_valid = 0;
    logic       in_last = 0;
    logic       out_ready = 1;
    logic [7:0] in_data = 0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_min;
    logic [3:0] out_idx;
    logic [4:0] out_count;
    logic       out_trunc;

    int   errs = 0;
    int   checks = 0;
    int   n_res = 0;
    int   n_exp = 0;
    int   or_ctl = 0;
    int   frame[$];
    res_t expq[$];
    res_t last_r;
    res_t r;
    bit   exp_rise = 0;
    int   m;
    int   ix;
    int   prev;

    min_reduce_int8_stream #(.WIDTH(8), .MAX_LEN(MAX), .IMPL_TYPE(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min),
        .out_idx(out_idx), .out_count(out_count), .out_trunc(out_trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level reference: collect accepted elements, reduce when the frame closes.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            n_exp -= expq.size();
            frame.delete();
            expq.delete();
            exp_rise = 0;
        end else begin
            if (exp_rise) chk("latency_valid", int'(out_valid), 1);
            exp_rise = 0;
            chk("ready_vs_valid", int'(in_ready), int'(!out_valid));
            if (out_valid) begin
                if (expq.size() == 0) chk("spurious_result", 1, 0);
                else begin
                    chk("min", int'($signed(out_min)), int'($signed(expq[0].mn)));
                    chk("idx", int'(out_idx), int'(expq[0].idx));
                    chk("count", int'(out_count), int'(expq[0].cnt));
                    chk("trunc", int'(out_trunc), int'(expq[0].tr));
                    if (out_ready) begin
                        last_r = '{out_min, out_idx, out_count, out_trunc};
                        n_res++;
                        void'(expq.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                frame.push_back(int'($signed(in_data)));
                if (in_last || frame.size() == MAX) begin
                    m = frame[0];
                    ix = 0;
                    for (int i = 1; i < frame.size(); i++)
                        if (frame[i] < m) begin
                            m = frame[i];
                            ix = i;
                        end
                    r = '{8'(m), 4'(ix), 5'(frame.size()), !in_last};
                    expq.push_back(r);
                    n_exp++;
                    exp_rise = 1;
                    frame.delete();
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = or_ctl == 0 ? 1'b1 : or_ctl == 2 ? 1'b0 : ($urandom_range(3, 0) != 0);
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d, input logic l, input int gmax);
        int g;
        int t;
        g = gmax > 0 ? int'($urandom_range(gmax, 0)) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1;
        in_data  = d;
        in_last  = l;
        t = 0;
        while (!in_ready && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        in_data  = 'x;
        in_last  = 'x;
    endtask

    task automatic wait_res(input int p);
        int t;
        t = 0;
        while (n_res == p && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (n_res == p) chk("result_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string nm, input int mn, input int idx, input int cnt, input int tr);
        chk({nm, "_min"}, int'($signed(last_r.mn)), mn);
        chk({nm, "_idx"}, int'(last_r.idx), idx);
        chk({nm, "_count"}, int'(last_r.cnt), cnt);
        chk({nm, "_trunc"}, int'(last_r.tr), tr);
    endtask

    initial begin
        int len;
        int t;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_min", int'(out_min), 0);
        chk("rst_idx", int'(out_idx), 0);
        chk("rst_count", int'(out_count), 0);
        chk("rst_trunc", int'(out_trunc), 0);
        @(posedge clk);
        #1;

        prev = n_res;
        send(8'd5, 0, 0);
        send(8'hFD, 0, 0);
        send(8'd7, 0, 0);
        send(8'hFD, 1, 0);
        wait_res(prev);
        pin("t1", -3, 1, 4, 0);

        prev = n_res;
        send(8'h80, 1, 0);
        wait_res(prev);
        pin("t2", -128, 0, 1, 0);

        prev = n_res;
        for (int i = 0; i < 16; i++) send(8'(10 - i), 0, 0);
        wait_res(prev);
        pin("t3", -5, 15, 16, 1);

        prev = n_res;
        for (int i = 0; i < 16; i++) send(8'd0, i == 15, 1);
        wait_res(prev);
        pin("tlast16", 0, 0, 16, 0);

        or_ctl = 2;
        prev = n_res;
        send(8'd1, 0, 0);
        send(8'd2, 1, 0);
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("t4_valid_up", int'(out_valid), 1);
        repeat (5) begin
            in_valid = ~in_valid;
            in_data  = 8'h81;
            in_last  = 1;
            @(posedge clk);
            #1;
            chk("t4_hold_ready", int'(in_ready), 0);
            chk("t4_hold_valid", int'(out_valid), 1);
        end
        in_valid = 0;
        or_ctl = 0;
        wait_res(prev);
        pin("t4a", 1, 0, 2, 0);
        prev = n_res;
        send(8'd127, 0, 0);
        send(8'h80, 1, 0);
        wait_res(prev);
        pin("t4b", -128, 1, 2, 0);

        send(8'd1, 0, 0);
        send(8'd2, 0, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        repeat (4) begin
            @(negedge clk);
            chk("t6_no_valid", int'(out_valid), 0);
            chk("t6_count_cleared", int'(out_count), 0);
        end
        @(posedge clk);
        #1;
        prev = n_res;
        send(8'd4, 0, 0);
        send(8'd3, 1, 0);
        wait_res(prev);
        pin("t6", 3, 1, 2, 0);

        or_ctl = 1;
        for (int f = 0; f < 1000; f++) begin
            len = int'($urandom_range(18, 1));
            for (int i = 0; i < len; i++) send(8'($urandom), i == len - 1, 2);
        end
        t = 0;
        while (expq.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        or_ctl = 0;
        repeat (3) @(posedge clk);
        chk("drain_empty", expq.size(), 0);
        chk("lost_or_dup", n_res, n_exp);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
